// File: rtl/ps2_key_matrix_if.sv
// PPI-side matrix read bus and external scancode lookup ROM bus.
interface ps2_key_matrix_if;
    logic [3:0] matrix_y;
    logic [7:0] matrix_x;
    logic [8:0] rom_address;
    logic [7:0] rom_rdata;

    // Keyboard front end: answers row reads and drives ROM lookups
    modport master (
        input  matrix_y,
        input  rom_rdata,
        output matrix_x,
        output rom_address
    );

    // PPI and ROM side
    modport slave (
        output matrix_y,
        output rom_rdata,
        input  matrix_x,
        input  rom_address
    );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 receiver, scancode prefix decoder and 11x8 active-low MSX key matrix.
module ps2_key_matrix #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_key_matrix_if.master  bus,
    output logic              frame_error
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_IDLE, DEC_LOOKUP, DEC_APPLY} dec_state_t;

    logic [1:0]    clk_meta, data_meta;
    logic          clk_sync, data_sync;
    logic          filt_clk;
    logic [FW-1:0] flt_cnt;
    logic          ev, ev_data;

    rx_state_t     rx_state, rx_next;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] idle_cnt;
    logic          byte_valid, err_c;

    dec_state_t    dec_state, dec_next;
    logic          e0_flag, f0_flag;
    logic [2:0]    skip_cnt;
    logic          load_addr, set_e0, set_f0, load_skip, dec_skip, bat, apply, clr_flags;
    logic [7:0]    matrix [0:10];

    assign clk_sync  = clk_meta[1];
    assign data_sync = data_meta[1];

    // Two-flop synchronisers for the asynchronous PS/2 lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= '1;
            data_meta <= '1;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk};
            data_meta <= {data_meta[0], ps2_data};
        end
    end

    // Glitch filter on ps2_clk; a filtered falling edge yields one sample event with its data bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
            ev       <= 1'b0;
            ev_data  <= 1'b1;
        end else begin
            ev      <= filt_clk && !clk_sync && (flt_cnt == FW'(FILTER_LEN - 1));
            ev_data <= data_sync;
            if (clk_sync == filt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    // Frame receiver state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    // Frame receiver next state; a stalled partial frame is abandoned by the timeout
    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        err_c      = 1'b0;
        if (rx_state != RX_IDLE && !ev && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_next = RX_IDLE;
            err_c   = 1'b1;
        end else if (ev) begin
            case (rx_state)
                RX_IDLE:   if (!ev_data) rx_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP: begin
                    rx_next = RX_IDLE;
                    if ((^{shift, parity_bit}) && ev_data) byte_valid = 1'b1;
                    else                                   err_c      = 1'b1;
                end
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    // Receiver shift register, bit counter, inter-event counter and error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift       <= '0;
            bit_cnt     <= '0;
            parity_bit  <= 1'b0;
            idle_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= err_c;
            if (ev || rx_state == RX_IDLE) idle_cnt <= '0;
            else                           idle_cnt <= idle_cnt + TW'(1);
            if (ev) begin
                case (rx_state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shift   <= {ev_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= ev_data;
                    default: ;
                endcase
            end
        end
    end

    // Decode state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dec_state <= DEC_IDLE;
        else          dec_state <= dec_next;
    end

    // Prefix/skip resolution and lookup sequencing; bytes arriving outside IDLE are dropped
    always_comb begin
        dec_next  = dec_state;
        load_addr = 1'b0;
        set_e0    = 1'b0;
        set_f0    = 1'b0;
        load_skip = 1'b0;
        dec_skip  = 1'b0;
        bat       = 1'b0;
        apply     = 1'b0;
        clr_flags = err_c;
        case (dec_state)
            DEC_IDLE: begin
                if (byte_valid) begin
                    if (skip_cnt != 3'd0)        dec_skip  = 1'b1;
                    else if (shift == 8'hE1)     load_skip = 1'b1;
                    else if (shift == 8'hE0)     set_e0    = 1'b1;
                    else if (shift == 8'hF0)     set_f0    = 1'b1;
                    else if (!e0_flag && !f0_flag && shift == 8'hAA) bat = 1'b1;
                    else if (!e0_flag && !f0_flag &&
                             (shift inside {8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF})) begin
                    end else begin
                        load_addr = 1'b1;
                        dec_next  = DEC_LOOKUP;
                    end
                end
            end
            DEC_LOOKUP: dec_next = DEC_APPLY;
            DEC_APPLY: begin
                apply     = bus.rom_rdata[7] && (bus.rom_rdata[6:3] <= 4'd10);
                clr_flags = 1'b1;
                dec_next  = DEC_IDLE;
            end
            default: dec_next = DEC_IDLE;
        endcase
    end

    // Prefix flags, Pause skip counter and ROM address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0_flag         <= 1'b0;
            f0_flag         <= 1'b0;
            skip_cnt        <= '0;
            bus.rom_address <= '0;
        end else begin
            if (clr_flags) begin
                e0_flag <= 1'b0;
                f0_flag <= 1'b0;
            end else begin
                if (set_e0) e0_flag <= 1'b1;
                if (set_f0) f0_flag <= 1'b1;
            end
            if (load_skip)     skip_cnt <= 3'd7;
            else if (dec_skip) skip_cnt <= skip_cnt - 3'd1;
            if (load_addr) bus.rom_address <= {e0_flag, shift};
        end
    end

    // Key matrix storage: BAT releases everything, APPLY writes one key bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < 11; r++) matrix[r] <= '1;
        end else if (bat) begin
            for (int unsigned r = 0; r < 11; r++) matrix[r] <= '1;
        end else if (apply) begin
            matrix[bus.rom_rdata[6:3]][bus.rom_rdata[2:0]] <= f0_flag;
        end
    end

    // Registered row read; rows beyond 10 read as all released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   bus.matrix_x <= '1;
        else if (bus.matrix_y <= 4'd10) bus.matrix_x <= matrix[bus.matrix_y];
        else                            bus.matrix_x <= '1;
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix with a behavioural keyboard model.
module tb_ps2_key_matrix;

    localparam int unsigned FLT  = 4;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 10;
    localparam int unsigned GAP  = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic frame_error;

    ps2_key_matrix_if bus ();

    ps2_key_matrix #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .bus         (bus),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:511];
    always @(posedge clk) bus.rom_rdata <= rom[bus.rom_address];

    int err_total = 0;
    always @(posedge clk) if (frame_error) err_total++;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_mat [0:10];
    logic       m_e0, m_f0;
    int         m_skip;
    logic [8:0] m_addr;

    function automatic void model_reset();
        for (int r = 0; r < 11; r++) m_mat[r] = 8'hFF;
        m_e0 = 0; m_f0 = 0; m_skip = 0; m_addr = 9'h000;
    endfunction

    function automatic void model_error();
        m_e0 = 0; m_f0 = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] r;
        int row;
        bit no_prefix;
        no_prefix = !m_e0 && !m_f0;
        if (m_skip > 0) m_skip = m_skip - 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_e0 = 1;
        else if (b == 8'hF0) m_f0 = 1;
        else if (no_prefix && b == 8'hAA) begin
            for (int k = 0; k < 11; k++) m_mat[k] = 8'hFF;
        end else if (no_prefix && (b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                                   b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
        end else begin
            m_addr = {m_e0, b};
            r = rom[m_addr];
            row = int'(r[6:3]);
            if (r[7] && row <= 10) m_mat[row][r[2:0]] = m_f0;
            m_e0 = 0; m_f0 = 0;
        end
    endfunction

    function automatic logic [7:0] model_row(input int y);
        return (y <= 10) ? m_mat[y] : 8'hFF;
    endfunction

    task automatic send_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = bad_par ? ^b : ~^b;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        if (bad_par) model_error();
        else         model_byte(b);
    endtask

    task automatic test_reset();
        int e0;
        reset_n = 1'b0;
        bus.matrix_y = 4'd0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.matrix_x !== 8'hFF) begin failures++; $display("FAIL reset_matrix_x got=%h exp=ff", bus.matrix_x); end
        checks++;
        if (bus.rom_address !== 9'h000) begin failures++; $display("FAIL reset_rom_address got=%h exp=000", bus.rom_address); end
        checks++;
        if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
        reset_n = 1'b1;
        model_reset();
        e0 = err_total;
        for (int y = 0; y < 16; y++) begin
            @(negedge clk) bus.matrix_y = 4'(y);
            @(negedge clk);
            checks++;
            if (bus.matrix_x !== 8'hFF) begin failures++; $display("FAIL reset_sweep y=%0d got=%h exp=ff", y, bus.matrix_x); end
        end
        checks++;
        if (err_total !== e0) begin failures++; $display("FAIL reset_no_error got=%0d exp=%0d", err_total, e0); end
    endtask

    task automatic test_press_release();
        send_frame(8'h1C, 0);
        checks++;
        if (bus.rom_address !== 9'h01C) begin failures++; $display("FAIL press_addr got=%h exp=01c", bus.rom_address); end
        @(negedge clk) bus.matrix_y = 4'd2;
        @(negedge clk);
        checks++;
        if (bus.matrix_x !== 8'hBF || m_mat[2] !== 8'hBF) begin failures++; $display("FAIL press_row2 got=%h exp=bf", bus.matrix_x); end
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        checks++;
        if (bus.matrix_x !== 8'hFF) begin failures++; $display("FAIL release_row2 got=%h exp=ff", bus.matrix_x); end
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        checks++;
        if (bus.rom_address !== 9'h175) begin failures++; $display("FAIL ext_addr got=%h exp=175", bus.rom_address); end
        for (int y = 0; y < 11; y++) begin
            @(negedge clk) bus.matrix_y = 4'(y);
            @(negedge clk);
            checks++;
            if (bus.matrix_x !== ((y == 8) ? 8'hDF : 8'hFF) || bus.matrix_x !== model_row(y)) begin
                failures++; $display("FAIL ext_row y=%0d got=%h exp=%h", y, bus.matrix_x, model_row(y));
            end
        end
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
    endtask

    task automatic test_parity_error();
        int e0;
        e0 = err_total;
        send_frame(8'h1C, 1);
        checks++;
        if (err_total - e0 !== 1) begin failures++; $display("FAIL parity_err_cycles got=%0d exp=1", err_total - e0); end
        @(negedge clk) bus.matrix_y = 4'd2;
        @(negedge clk);
        checks++;
        if (bus.matrix_x !== 8'hFF) begin failures++; $display("FAIL parity_row2 got=%h exp=ff", bus.matrix_x); end
        send_frame(8'h1C, 0);
        checks++;
        if (bus.matrix_x !== 8'hBF) begin failures++; $display("FAIL parity_recover got=%h exp=bf", bus.matrix_x); end
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_total;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        ps2_data = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        model_error();
        checks++;
        if (err_total - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_total - e0); end
        send_frame(8'h1C, 0);
        @(negedge clk) bus.matrix_y = 4'd2;
        @(negedge clk);
        checks++;
        if (bus.matrix_x !== 8'hBF) begin failures++; $display("FAIL timeout_recover got=%h exp=bf", bus.matrix_x); end
    endtask

    task automatic test_pause_and_bat();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_frame(seq[i], 0);
        checks++;
        if (bus.rom_address !== 9'h01C) begin failures++; $display("FAIL pause_no_lookup got=%h exp=01c", bus.rom_address); end
        checks++;
        if (bus.matrix_x !== 8'hBF) begin failures++; $display("FAIL pause_row2 got=%h exp=bf", bus.matrix_x); end
        send_frame(8'hAA, 0);
        for (int y = 0; y < 11; y++) begin
            @(negedge clk) bus.matrix_y = 4'(y);
            @(negedge clk);
            checks++;
            if (bus.matrix_x !== 8'hFF) begin failures++; $display("FAIL bat_row y=%0d got=%h exp=ff", y, bus.matrix_x); end
        end
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) reset_n = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (TMO + 20) @(negedge clk);
        send_frame(8'h1C, 0);
        @(negedge clk) bus.matrix_y = 4'd2;
        @(negedge clk);
        checks++;
        if (bus.matrix_x !== 8'hBF) begin failures++; $display("FAIL midreset_row2 got=%h exp=bf", bus.matrix_x); end
        checks++;
        if (bus.rom_address !== 9'h01C) begin failures++; $display("FAIL midreset_addr got=%h exp=01c", bus.rom_address); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit bad;
        int e0, y, sel;
        for (int n = 0; n < 32; n++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'hAA;
                6:       b = 8'hFA;
                default: b = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 7) == 0);
            e0 = err_total;
            send_frame(b, bad);
            checks++;
            if (err_total - e0 !== (bad ? 1 : 0)) begin
                failures++; $display("FAIL rand_err n=%0d got=%0d exp=%0d", n, err_total - e0, bad ? 1 : 0);
            end
            checks++;
            if (bus.rom_address !== m_addr) begin
                failures++; $display("FAIL rand_addr n=%0d got=%h exp=%h", n, bus.rom_address, m_addr);
            end
            y = int'($urandom_range(0, 15));
            @(negedge clk) bus.matrix_y = 4'(y);
            @(negedge clk);
            checks++;
            if (bus.matrix_x !== model_row(y)) begin
                failures++; $display("FAIL rand_row n=%0d y=%0d got=%h exp=%h", n, y, bus.matrix_x, model_row(y));
            end
        end
        for (int yy = 0; yy < 16; yy++) begin
            @(negedge clk) bus.matrix_y = 4'(yy);
            @(negedge clk);
            checks++;
            if (bus.matrix_x !== model_row(yy)) begin
                failures++; $display("FAIL rand_sweep y=%0d got=%h exp=%h", yy, bus.matrix_x, model_row(yy));
            end
        end
    endtask

    initial begin
        bus.matrix_y = 4'd0;
        for (int i = 0; i < 512; i++) begin
            rom[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rom[i][7] = 1'b1;
        end
        rom[9'h01C] = 8'h96;
        rom[9'h175] = 8'hC5;
        model_reset();
        test_reset();
        test_press_release();
        test_extended();
        test_parity_error();
        test_timeout();
        test_pause_and_bat();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
Keyboard front end that sits directly upstream of the PPI keyboard port.
- Receives PS/2 scancode frames and resolves E0/F0/E1 prefixes.
- Translates each code through an external synchronous lookup ROM.
- Maintains the 11x8 MSX key matrix and returns the row selected by PPI port C (matrix_y) as PPI port B data (matrix_x).
- All matrix data is active-low: 0 = pressed.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered level changes.
TIMEOUT_CYCLES, 20000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (about 233 us at 85.909 MHz).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
ps2_clk  in  1  PS/2 clock line, asynchronous, receive only.
ps2_data  in  1  PS/2 data line, asynchronous, receive only.
matrix_y  in  4  row select from PPI port C bits 3:0.
matrix_x  out  8  selected row to PPI port B, active-low.
rom_address  out  9  lookup address {e0_flag, scancode}.
rom_rdata  in  8  lookup result {mapped, row[3:0], col[2:0]}; valid exactly 1 clk after rom_address.
frame_error  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
Reset (reset_n low, asynchronous):
- All 11 matrix rows = FFh; matrix_x = FFh; frame_error = 0; rom_address = 000h.
- Both FSMs go to IDLE; prefix flags and skip counter are cleared.
- Reset asserted mid-frame discards the partial frame. No event is emitted.

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filtered clock changes level only after FILTER_LEN equal consecutive samples.
- A sample event is a filtered falling edge. The synchronised ps2_data is captured at that edge.

Frame receiver FSM (IDLE, DATA, PARITY, STOP):
- IDLE: on an event with data=0, go to DATA with bit count 0. An event with data=1 is ignored.
- DATA: shift in LSB first. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit, go to STOP.
- STOP: frame is good if the total number of 1s in data plus parity is odd AND the stop bit = 1. A good frame produces a one-cycle byte_valid (internal). Otherwise frame_error pulses. Both cases return to IDLE.
- Timeout: the idle counter is cleared on every event. In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear prefix flags.

Decode FSM (IDLE, LOOKUP, APPLY), evaluated on byte_valid:
- Skip counter nonzero: decrement it and drop the byte. This takes precedence over all rules below.
- E1h: skip counter = 7 (Pause sequence is ignored).
- E0h: set e0_flag. F0h: set f0_flag.
- AAh with no prefix pending (BAT): all rows = FFh in the next cycle.
- FAh, EEh, FEh, FCh, 00h, FFh with no prefix pending: ignored.
- Any other byte: drive rom_address = {e0_flag, byte}, go to LOOKUP.
- LOOKUP: wait 1 cycle, then go to APPLY.
- APPLY: if rom_rdata[7]=1 and row <= 10, set matrix[row][col] = f0_flag (release = 1, press = 0). Otherwise do nothing. Clear e0_flag and f0_flag, return to IDLE.
- Latency from the stop-bit event to the matrix update: 3 clk.
- Bytes cannot arrive faster than the decode FSM (at least 11 x FILTER_LEN cycles apart). A byte_valid outside IDLE therefore never occurs. If it does anyway, it is dropped.
- frame_error clears e0_flag and f0_flag; the skip counter is kept.
- Repeated make codes (typematic) rewrite the same bit, with no side effect.

Matrix read:
- matrix_x is registered: matrix_x <= (matrix_y <= 10) ? matrix[matrix_y] : FFh, giving 1 clk latency.
- If an update and a read of the same row happen in the same cycle, matrix_x shows the old value, then the new value on the next cycle.

Test Plan:
1. Reset: sweep matrix_y 0..15 -> matrix_x = FFh for every row, frame_error never asserted.
2. Frame 1Ch with ROM(01Ch) = {1,2,6} -> rom_address = 01Ch; with matrix_y=2, matrix_x = BFh. Then send F0h,1Ch -> matrix_x = FFh.
3. Frames E0h,75h with ROM(175h) = {1,8,5} -> rom_address = 175h; row 8 = DFh; rows 0..7 and 9..10 remain FFh.
4. Frame 1Ch sent with even parity -> frame_error high for exactly 1 clk, row 2 stays FFh. A following correct 1Ch frame sets row 2 = BFh.
5. Send start bit plus 4 data bits, then hold ps2_clk high for more than TIMEOUT_CYCLES -> one frame_error pulse. The next full 1Ch frame decodes normally.
6. Press 1Ch (row 2 = BFh), send E1h,14h,77h,E1h,F0h,14h,F0h,77h -> no matrix change and no ROM lookup. Then send AAh -> all rows = FFh.
